// File: rtl/cross_seq_pkg.sv
// Shared types for the cross-product sequencer: FSM states, step encoding, default width.
// CROSS_SEQ_DOT_EN adds the three dot-product steps.
package cross_pkg;

  localparam int unsigned W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } state_e;

`ifdef CROSS_SEQ_DOT_EN
  typedef enum logic [3:0] {
    S_CX_P,
    S_CX_M,
    S_CY_P,
    S_CY_M,
    S_CZ_P,
    S_CZ_M,
    S_DX,
    S_DY,
    S_DZ
  } step_e;
  localparam step_e LAST_STEP = S_DZ;
`else
  typedef enum logic [2:0] {
    S_CX_P,
    S_CX_M,
    S_CY_P,
    S_CY_M,
    S_CZ_P,
    S_CZ_M
  } step_e;
  localparam step_e LAST_STEP = S_CZ_M;
`endif

endpackage

// File: rtl/cross_seq_if.sv
// Operand/result handshake bundle for cross_seq; dot exists only with CROSS_SEQ_DOT_EN.
interface cross_seq_if
  import cross_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
);

  logic                  in_valid;
  logic                  in_ready;
  logic signed [W-1:0]   a_x, a_y, a_z;
  logic signed [W-1:0]   b_x, b_y, b_z;
  logic                  out_valid;
  logic                  out_ready;
  logic signed [2*W-1:0] c_x, c_y, c_z;
`ifdef CROSS_SEQ_DOT_EN
  logic signed [2*W+1:0] dot;
`endif
  logic                  busy;

`ifdef CROSS_SEQ_DOT_EN
  modport slave (
    input  in_valid, a_x, a_y, a_z, b_x, b_y, b_z, out_ready,
    output in_ready, out_valid, c_x, c_y, c_z, dot, busy
  );
  modport master (
    output in_valid, a_x, a_y, a_z, b_x, b_y, b_z, out_ready,
    input  in_ready, out_valid, c_x, c_y, c_z, dot, busy
  );
`else
  modport slave (
    input  in_valid, a_x, a_y, a_z, b_x, b_y, b_z, out_ready,
    output in_ready, out_valid, c_x, c_y, c_z, busy
  );
  modport master (
    output in_valid, a_x, a_y, a_z, b_x, b_y, b_z, out_ready,
    input  in_ready, out_valid, c_x, c_y, c_z, busy
  );
`endif

endinterface

// File: rtl/cross_seq_mul.sv
// Shared combinational signed W x W -> 2W multiplier used by every cross_seq step.
module seq_mul #(
  parameter int unsigned W = 8
) (
  input  logic signed [W-1:0]   a,
  input  logic signed [W-1:0]   b,
  output logic signed [2*W-1:0] p
);

  always_comb begin
    p = (2*W)'(a) * (2*W)'(b);
  end

endmodule

// File: rtl/cross_seq.sv
// Sequential 3-D cross product (and optional dot product under CROSS_SEQ_DOT_EN)
// using one shared multiplier and one accumulating adder/subtractor.
module cross_seq
  import cross_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  cross_seq_if.slave  bus
);

  localparam int unsigned PW = 2 * W;
`ifdef CROSS_SEQ_DOT_EN
  localparam int unsigned ACC_W = 2 * W + 2;
  localparam int unsigned N_ACC = 4;
`else
  localparam int unsigned ACC_W = 2 * W + 1;
  localparam int unsigned N_ACC = 3;
`endif

  typedef logic signed [ACC_W-1:0] acc_t;

  state_e              state_q, state_d;
  step_e               step_q, step_d;
  logic signed [W-1:0] a_q [3];
  logic signed [W-1:0] a_d [3];
  logic signed [W-1:0] b_q [3];
  logic signed [W-1:0] b_d [3];
  acc_t                acc_q [N_ACC];
  acc_t                acc_d [N_ACC];

  logic signed [W-1:0]  mul_a, mul_b;
  logic signed [PW-1:0] prod;
  logic [1:0]           acc_sel;
  logic                 acc_sub;
  acc_t                 prod_ext;
  acc_t                 acc_sum;

  // Index 0/1/2 = x/y/z for operands; accumulator 3 is the dot product.
  always_comb begin
    mul_a   = '0;
    mul_b   = '0;
    acc_sel = 2'd0;
    acc_sub = 1'b0;
    case (step_q)
      S_CX_P: begin mul_a = a_q[1]; mul_b = b_q[2]; acc_sel = 2'd0; acc_sub = 1'b0; end
      S_CX_M: begin mul_a = a_q[2]; mul_b = b_q[1]; acc_sel = 2'd0; acc_sub = 1'b1; end
      S_CY_P: begin mul_a = a_q[2]; mul_b = b_q[0]; acc_sel = 2'd1; acc_sub = 1'b0; end
      S_CY_M: begin mul_a = a_q[0]; mul_b = b_q[2]; acc_sel = 2'd1; acc_sub = 1'b1; end
      S_CZ_P: begin mul_a = a_q[0]; mul_b = b_q[1]; acc_sel = 2'd2; acc_sub = 1'b0; end
      S_CZ_M: begin mul_a = a_q[1]; mul_b = b_q[0]; acc_sel = 2'd2; acc_sub = 1'b1; end
`ifdef CROSS_SEQ_DOT_EN
      S_DX:   begin mul_a = a_q[0]; mul_b = b_q[0]; acc_sel = 2'd3; acc_sub = 1'b0; end
      S_DY:   begin mul_a = a_q[1]; mul_b = b_q[1]; acc_sel = 2'd3; acc_sub = 1'b0; end
      S_DZ:   begin mul_a = a_q[2]; mul_b = b_q[2]; acc_sel = 2'd3; acc_sub = 1'b0; end
`endif
      default: begin mul_a = '0; mul_b = '0; end
    endcase
  end

  seq_mul #(.W(W)) u_mul (
    .a (mul_a),
    .b (mul_b),
    .p (prod)
  );

  always_comb begin
    prod_ext = acc_t'({{(ACC_W-PW){prod[PW-1]}}, prod});
    acc_sum  = acc_sub ? (acc_q[acc_sel] - prod_ext) : (acc_q[acc_sel] + prod_ext);
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d[0]  = bus.a_x;
          a_d[1]  = bus.a_y;
          a_d[2]  = bus.a_z;
          b_d[0]  = bus.b_x;
          b_d[1]  = bus.b_y;
          b_d[2]  = bus.b_z;
          acc_d   = '{default: '0};
          step_d  = S_CX_P;
          state_d = MUL;
        end
      end
      MUL: begin
        acc_d[acc_sel] = acc_sum;
        if (step_q == LAST_STEP) begin
          state_d = DONE;
        end else begin
          step_d = step_e'(step_q + 1'b1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= S_CX_P;
      a_q     <= '{default: '0};
      b_q     <= '{default: '0};
      acc_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
    end
  end

  // Results are the low 2W bits; by construction every component fits there exactly.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == MUL) || (state_q == DONE);
  assign bus.c_x       = acc_q[0][PW-1:0];
  assign bus.c_y       = acc_q[1][PW-1:0];
  assign bus.c_z       = acc_q[2][PW-1:0];
`ifdef CROSS_SEQ_DOT_EN
  assign bus.dot       = acc_q[3];
`endif

endmodule

// File: tb/tb_cross_seq.sv
// Scoreboard bench for cross_seq: directed vectors, expectations queued at accept,
// checked by an independent output monitor. Honours CROSS_SEQ_DOT_EN.
module tb_cross_seq;
  import cross_pkg::*;

`ifdef CROSS_SEQ_DOT_EN
  localparam int unsigned LAT    = 9;
  localparam int unsigned PERIOD = 11;
`else
  localparam int unsigned LAT    = 6;
  localparam int unsigned PERIOD = 8;
`endif

  typedef struct {
    int          cx;
    int          cy;
    int          cz;
    int          dt;
    int unsigned acc_edge;
  } exp_t;

  logic clk;
  logic rst;
  cross_seq_if #(.W(8)) bus ();

  cross_seq #(.W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned stall    = 0;
  int unsigned last_hs_edge = 0;
  int unsigned prev_acc_edge = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Output monitor and consumer: drives out_ready, checks latency, stability and values.
  initial begin
    bit prev_valid;
    prev_valid    = 1'b0;
    bus.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0;
        continue;
      end
      if (bus.out_valid) begin
        if (!prev_valid) begin
          if (sb.size() == 0) chk("unexpected_out_valid", 1, 0);
          else chk("latency", longint'(cyc - sb[0].acc_edge), LAT);
        end
        if (stall > 0) begin
          bus.out_ready = 1'b0;
          stall--;
        end else begin
          bus.out_ready = 1'b1;
        end
        chk("in_ready_in_done", bus.in_ready, 0);
        chk("busy_in_done", bus.busy, 1);
        if (sb.size() > 0) begin
          chk("c_x", bus.c_x, sb[0].cx);
          chk("c_y", bus.c_y, sb[0].cy);
          chk("c_z", bus.c_z, sb[0].cz);
`ifdef CROSS_SEQ_DOT_EN
          chk("dot", bus.dot, sb[0].dt);
`endif
          if (bus.out_ready) begin
            void'(sb.pop_front());
            last_hs_edge = cyc + 1;
          end
        end
      end else begin
        bus.out_ready = 1'b1;
      end
      prev_valid = bus.out_valid;
    end
  end

  // mode: 0 none, 1 accept must follow previous handshake by one edge, 2 back-to-back period
  task automatic send(input logic signed [7:0] ax, input logic signed [7:0] ay,
                      input logic signed [7:0] az, input logic signed [7:0] bx,
                      input logic signed [7:0] by, input logic signed [7:0] bz,
                      input int cx, input int cy, input int cz, input int dt,
                      input bit push, input int unsigned mode);
    exp_t        e;
    int unsigned n;
    bus.a_x = ax; bus.a_y = ay; bus.a_z = az;
    bus.b_x = bx; bus.b_y = by; bus.b_z = bz;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      chk("accept_timeout", 0, 1);
      bus.in_valid = 1'b0;
      return;
    end
    e.cx = cx; e.cy = cy; e.cz = cz; e.dt = dt;
    e.acc_edge = cyc + 1;
    if (mode == 1) chk("accept_after_handshake", e.acc_edge, last_hs_edge + 1);
    if (mode == 2) chk("job_period", e.acc_edge - prev_acc_edge, PERIOD);
    prev_acc_edge = e.acc_edge;
    if (push) sb.push_back(e);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a_x = 8'($urandom); bus.a_y = 8'($urandom); bus.a_z = 8'($urandom);
    bus.b_x = 8'($urandom); bus.b_y = 8'($urandom); bus.b_z = 8'($urandom);
    chk("busy_in_mul", bus.busy, 1);
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (sb.size() > 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_in_ready"}, bus.in_ready, 1);
    chk({tag, "_c_x"}, bus.c_x, 0);
    chk({tag, "_c_y"}, bus.c_y, 0);
    chk({tag, "_c_z"}, bus.c_z, 0);
`ifdef CROSS_SEQ_DOT_EN
    chk({tag, "_dot"}, bus.dot, 0);
`endif
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.a_x = '0; bus.a_y = '0; bus.a_z = '0;
    bus.b_x = '0; bus.b_y = '0; bus.b_z = '0;
    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    send(1, 0, 0, 0, 1, 0,         0, 0, 1,     0, 1'b1, 0);
    send(1, 2, 3, 4, 5, 6,        -3, 6, -3,   32, 1'b1, 2);
    send(0, -128, -128, 0, 127, -128,  32640, 0, 0, 128, 1'b1, 0);
    send(0, -128, -128, 0, -128, 127, -32640, 0, 0, 128, 1'b1, 0);
    send(-1, 2, -3, 4, -5, 6,     -3, -6, -3, -32, 1'b1, 0);
    drain();

    // Consumer stalls 10 cycles while the next job's in_valid is already high
    stall = 10;
    send(2, 3, 4, 4, 6, 8,         0, 0, 0,    58, 1'b1, 0);
    send(1, 2, 3, 4, 5, 6,        -3, 6, -3,   32, 1'b1, 1);
    drain();

    // Abort a job at step 3 with reset; nothing may be produced for it
    send(3, 4, 5, 6, 7, 8,         0, 0, 0,     0, 1'b0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_zero("mid_reset");
    send(1, 0, 0, 0, 1, 0,         0, 0, 1,     0, 1'b1, 0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
